// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the baud-divider calculation used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // Clocks per oversample tick, rounded down.
    function automatic int calc_div(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks; i_Clear
// holds the count at zero so the tick phase restarts when the clear drops.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic i_CLK,
    input  logic i_RESET_n,
    input  logic i_Clear,
    output logic o_Tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            cnt <= '0;
        end else if (i_Clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_Tick = !i_Clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver feeding the receive FIFO write port.
// Define UART_RX_PARITY_EN to expect an even parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET_n,
    input  logic                  i_RX,
    input  logic                  i_FIFO_Full,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Valid,
    output logic                  o_Frame_Error,
    output logic                  o_Parity_Error,
    output logic                  o_Overrun,
    output logic                  o_Busy
);

    localparam int              DIV       = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int              BW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [3:0]      MID_TICK  = 4'(MID_SAMPLE);
    localparam logic [3:0]      LAST_TICK = 4'(OVERSAMPLE - 1);

    uart_state_t           state;
    logic                  rx_meta, rx_sync, rx_prev;
    logic                  rx_fall;
    logic                  tick;
    logic [3:0]            sample_cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
    logic                  parity_bad;
    logic                  parity_pulse;
`endif

    // i_RX is asynchronous; idle-high reset values keep reset release from
    // looking like a start edge.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev && !rx_sync;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .i_CLK    (i_CLK),
        .i_RESET_n(i_RESET_n),
        .i_Clear  (state == IDLE),
        .o_Tick   (tick)
    );

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state         <= IDLE;
            sample_cnt    <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            o_Data        <= '0;
            o_Valid       <= 1'b0;
            o_Frame_Error <= 1'b0;
            o_Overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad    <= 1'b0;
            parity_pulse  <= 1'b0;
`endif
        end else begin
            o_Valid       <= 1'b0;
            o_Frame_Error <= 1'b0;
            o_Overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_pulse  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    sample_cnt <= '0;
                    bit_idx    <= '0;
`ifdef UART_RX_PARITY_EN
                    parity_bad <= 1'b0;
`endif
                    if (rx_fall) state <= START;
                end
                START: if (tick) begin
                    // Mid start bit: a high line here was a glitch, not a frame.
                    if (sample_cnt == MID_TICK) begin
                        sample_cnt <= '0;
                        state      <= rx_sync ? IDLE : DATA;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                DATA: if (tick) begin
                    sample_cnt <= sample_cnt + 1'b1;
                    if (sample_cnt == LAST_TICK) begin
                        shift_reg <= {rx_sync, shift_reg[DATA_WIDTH-1:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    sample_cnt <= sample_cnt + 1'b1;
                    if (sample_cnt == LAST_TICK) begin
                        parity_bad <= rx_sync ^ (^shift_reg);
                        state      <= STOP;
                    end
                end
`endif
                STOP: if (tick) begin
                    sample_cnt <= sample_cnt + 1'b1;
                    // Leaving here at mid stop bit lets a back-to-back start edge be seen.
                    if (sample_cnt == LAST_TICK) begin
                        state <= IDLE;
                        if (!rx_sync) begin
                            o_Frame_Error <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad) begin
                            parity_pulse <= 1'b1;
`endif
                        end else begin
                            o_Data    <= shift_reg;
                            o_Valid   <= 1'b1;
                            o_Overrun <= i_FIFO_Full;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign o_Parity_Error = parity_pulse;
`else
    assign o_Parity_Error = 1'b0;
`endif

    assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 160 clocks per bit; compile with
// UART_RX_PARITY_EN defined to add the parity frames.
module tb_uart_rx;

    localparam int CLK_FREQ_HZ = 1_600_000;
    localparam int BAUD_RATE   = 10_000;
    localparam int BIT_CLKS    = 160;

    logic       i_CLK;
    logic       i_RESET_n;
    logic       i_RX;
    logic       i_FIFO_Full;
    logic [7:0] o_Data;
    logic       o_Valid;
    logic       o_Frame_Error;
    logic       o_Parity_Error;
    logic       o_Overrun;
    logic       o_Busy;

    int n_checks = 0;
    int n_fail   = 0;

    int n_valid        = 0;
    int n_ferr         = 0;
    int n_perr         = 0;
    int n_ovr          = 0;
    int ovr_alone      = 0;
    int err_with_valid = 0;
    int wide_pulses    = 0;

    logic [7:0] exp_q[$];
    logic       prev_valid, prev_ferr, prev_perr, prev_ovr;

    uart_rx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD_RATE  (BAUD_RATE),
        .DATA_WIDTH (8)
    ) dut (
        .i_CLK         (i_CLK),
        .i_RESET_n     (i_RESET_n),
        .i_RX          (i_RX),
        .i_FIFO_Full   (i_FIFO_Full),
        .o_Data        (o_Data),
        .o_Valid       (o_Valid),
        .o_Frame_Error (o_Frame_Error),
        .o_Parity_Error(o_Parity_Error),
        .o_Overrun     (o_Overrun),
        .o_Busy        (o_Busy)
    );

    // Clock and reset
    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard / monitor, sampled on the falling edge
    always @(negedge i_CLK) begin
        if (i_RESET_n) begin
            if (o_Valid) begin
                n_valid++;
                if (exp_q.size() == 0) check("unexpected_valid", 32'(o_Data), 32'hDEAD);
                else                   check("rx_data", 32'(o_Data), 32'(exp_q.pop_front()));
                if (o_Frame_Error || o_Parity_Error) err_with_valid++;
            end
            if (o_Frame_Error)  n_ferr++;
            if (o_Parity_Error) n_perr++;
            if (o_Overrun) begin
                n_ovr++;
                if (!o_Valid) ovr_alone++;
            end
            if ((o_Valid && prev_valid) || (o_Frame_Error && prev_ferr) ||
                (o_Parity_Error && prev_perr) || (o_Overrun && prev_ovr))
                wide_pulses++;
        end
        prev_valid = o_Valid;
        prev_ferr  = o_Frame_Error;
        prev_perr  = o_Parity_Error;
        prev_ovr   = o_Overrun;
    end

    // Driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge i_CLK);
    endtask

    task automatic send_bit(input logic b);
        i_RX = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
        i_RX = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask
`endif

    initial begin
        int rise;
        int fall;
        int v0;

        i_RX        = 1'b1;
        i_FIFO_Full = 1'b0;
        i_RESET_n   = 1'b0;
        prev_valid  = 1'b0;
        prev_ferr   = 1'b0;
        prev_perr   = 1'b0;
        prev_ovr    = 1'b0;
        wait_clks(4);

        // Reset values
        check("rst_data",   32'(o_Data), 32'h00);
        check("rst_valid",  32'(o_Valid), 32'h0);
        check("rst_ferr",   32'(o_Frame_Error), 32'h0);
        check("rst_perr",   32'(o_Parity_Error), 32'h0);
        check("rst_ovr",    32'(o_Overrun), 32'h0);
        check("rst_busy",   32'(o_Busy), 32'h0);
        i_RESET_n = 1'b1;

        // Idle line: nothing happens
        wait_clks(1000);
        check("idle_valid", 32'(n_valid), 32'd0);
        check("idle_ferr",  32'(n_ferr), 32'd0);
        check("idle_perr",  32'(n_perr), 32'd0);
        check("idle_busy",  32'(o_Busy), 32'h0);

        // Back-to-back frames
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(200);
        check("b2b_count", 32'(n_valid), 32'd3);
        check("b2b_ferr",  32'(n_ferr), 32'd0);
        check("b2b_perr",  32'(n_perr), 32'd0);
        check("b2b_data",  32'(o_Data), 32'hFF);

        // False start: 40-clock low glitch
        rise = -1;
        fall = -1;
        i_RX = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge i_CLK);
            if (k == 40) i_RX = 1'b1;
            if (o_Busy && rise < 0) rise = k;
            if (!o_Busy && rise >= 0 && fall < 0) fall = k;
        end
        check("fs_busy_rise", 32'(rise), 32'd3);
        check("fs_busy_fall", 32'(fall), 32'd83);
        check("fs_no_valid",  32'(n_valid), 32'd3);

        // Framing error keeps the last good byte
        send_frame(8'h3C, 1'b0);
        wait_clks(200);
        check("fe_count", 32'(n_ferr), 32'd1);
        check("fe_no_valid", 32'(n_valid), 32'd3);
        check("fe_data_kept", 32'(o_Data), 32'hFF);
        check("fe_busy", 32'(o_Busy), 32'h0);

        // Overrun with the FIFO full
        exp_q.push_back(8'h81);
        i_FIFO_Full = 1'b1;
        send_frame(8'h81, 1'b1);
        i_FIFO_Full = 1'b0;
        wait_clks(200);
        check("ovr_valid", 32'(n_valid), 32'd4);
        check("ovr_count", 32'(n_ovr), 32'd1);
        check("ovr_coincident", 32'(ovr_alone), 32'd0);
        check("ovr_data", 32'(o_Data), 32'h81);

        // Reset in the middle of the data bits of 0x5A
        v0 = n_valid;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_busy_before", 32'(o_Busy), 32'h1);
        i_RESET_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(o_Busy), 32'h0);
        check("mid_rst_data", 32'(o_Data), 32'h00);
        i_RX = 1'b1;
        wait_clks(3);
        i_RESET_n = 1'b1;
        wait_clks(2000);
        check("mid_no_valid", 32'(n_valid), 32'(v0));
        check("mid_idle", 32'(o_Busy), 32'h0);

        // Recovery after reset
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_clks(200);
        check("rec_valid", 32'(n_valid), 32'(v0 + 1));
        check("rec_data", 32'(o_Data), 32'h5A);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit is 1
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        wait_clks(200);
        check("par_ok_valid", 32'(n_valid), 32'(v0 + 2));
        check("par_ok_data", 32'(o_Data), 32'h07);
        check("par_ok_perr", 32'(n_perr), 32'd0);
        send_frame_par(8'h07, 1'b0);
        wait_clks(200);
        check("par_bad_perr", 32'(n_perr), 32'd1);
        check("par_bad_no_valid", 32'(n_valid), 32'(v0 + 2));
`else
        check("noparity_perr", 32'(n_perr), 32'd0);
`endif

        // Global pulse-shape and scoreboard checks
        check("pulse_width", 32'(wide_pulses), 32'd0);
        check("err_with_valid", 32'(err_with_valid), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
